// File: rtl/s2m_dma.sv
// Stream-to-memory DMA: packs an 8-bit AXI-stream little-endian into 32-bit words
// and writes them over AXI-lite. Optional completion interrupt under S2M_DMA_IRQ_EN.
module s2m_dma #(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       s_cpuif_req,
  input  logic                       s_cpuif_req_is_wr,
  input  logic [4:0]                 s_cpuif_addr,
  input  logic [31:0]                s_cpuif_wr_data,
  input  logic [31:0]                s_cpuif_wr_biten,
  output logic                       s_cpuif_rd_ack,
  output logic [31:0]                s_cpuif_rd_data,
  output logic                       s_cpuif_wr_ack,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]      m_axil_awaddr,
  output logic [2:0]                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [31:0]                m_axil_wdata,
  output logic [3:0]                 m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [31:0]                m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready,
  output logic                       o_irq
);

  // state    | meaning
  // IDLE     | waiting for start
  // COLLECT  | accepting beats into the word buffer
  // WRITE    | AW and W issued, each drops on its own handshake
  // RESP     | waiting for the write response
  // DONE     | publish COUNT and set done (one cycle)
  typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_RESP, ST_DONE} state_t;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_ADDR   = 5'h08;
  localparam logic [4:0] A_LEN    = 5'h0C;
  localparam logic [4:0] A_COUNT  = 5'h10;

  state_t state, state_nxt;

  logic                  start_pend, done_q, ovf_q, berr_q, irq_en_rd;
  logic [31:0]           addr_q;
  logic [15:0]           len_q, count_q, len_lat, bytes_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [13:0]           word_idx;
  logic [31:0]           data_q;
  logic [3:0]            strb_q;
  logic                  last_q, aw_done, w_done;

  logic        wr_stb, rd_stb, start_go, beat, store, flush;
  logic [1:0]  lane;
  logic [3:0]  strb_upd;
  logic [3:1]  w1c;
  logic [31:0] rd_val, addr_new;
  logic [15:0] len_new;
  logic        unused_ok;

  assign unused_ok = &{1'b0, m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid};

  assign wr_stb   = s_cpuif_req & s_cpuif_req_is_wr;
  assign rd_stb   = s_cpuif_req & ~s_cpuif_req_is_wr;
  assign start_go = (state == ST_IDLE) & start_pend;
  assign w1c      = (wr_stb && s_cpuif_addr == A_STATUS) ?
                    (s_cpuif_wr_data[3:1] & s_cpuif_wr_biten[3:1]) : 3'b000;
  assign addr_new = (addr_q & ~s_cpuif_wr_biten) | (s_cpuif_wr_data & s_cpuif_wr_biten);
  assign len_new  = (len_q & ~s_cpuif_wr_biten[15:0]) |
                    (s_cpuif_wr_data[15:0] & s_cpuif_wr_biten[15:0]);

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign store    = beat & (bytes_q < len_lat);
  assign lane     = bytes_q[1:0];
  assign strb_upd = strb_q | (store ? (4'b0001 << lane) : 4'b0000);
  // A word goes out when lane 3 fills, or at tlast if anything is buffered.
  assign flush    = (store & (lane == 2'd3)) | (beat & s_axis_tlast & (strb_upd != 4'b0000));

  assign m_axil_awaddr  = base_q + ADDR_WIDTH'({word_idx, 2'b00});
  assign m_axil_awprot  = 3'b000;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = strb_q;
  assign m_axil_araddr  = '0;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = 1'b0;
  assign m_axil_rready  = 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    s_axis_tready  = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    case (state)
      ST_IDLE: if (start_pend) state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        s_axis_tready = 1'b1;
        if (beat) begin
          if (flush)             state_nxt = ST_WRITE;
          else if (s_axis_tlast) state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        m_axil_awvalid = ~aw_done;
        m_axil_wvalid  = ~w_done;
        if ((aw_done | m_axil_awready) & (w_done | m_axil_wready)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) state_nxt = last_q ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q   <= '0;
      len_lat  <= '0;
      bytes_q  <= '0;
      word_idx <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      last_q   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_pend) begin
          base_q   <= addr_q[ADDR_WIDTH-1:0];
          len_lat  <= len_q;
          bytes_q  <= '0;
          word_idx <= '0;
          strb_q   <= '0;
          last_q   <= 1'b0;
        end
        ST_COLLECT: if (beat) begin
          if (store) begin
            data_q[{lane, 3'b000} +: 8] <= s_axis_tdata;
            bytes_q <= bytes_q + 16'd1;
          end
          strb_q <= strb_upd;
          last_q <= s_axis_tlast;
        end
        ST_WRITE: begin
          if (state_nxt == ST_RESP) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (m_axil_awvalid & m_axil_awready) aw_done <= 1'b1;
            if (m_axil_wvalid & m_axil_wready)   w_done  <= 1'b1;
          end
        end
        ST_RESP: if (m_axil_bvalid && !last_q) begin
          strb_q   <= '0;
          word_idx <= word_idx + 14'd1;
        end
        default: ;
      endcase
    end
  end

  // Hardware sets take priority over a same-cycle W1C.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_cpuif_wr_ack  <= 1'b0;
      s_cpuif_rd_ack  <= 1'b0;
      s_cpuif_rd_data <= '0;
      start_pend      <= 1'b0;
      addr_q          <= '0;
      len_q           <= '0;
      count_q         <= '0;
      done_q          <= 1'b0;
      ovf_q           <= 1'b0;
      berr_q          <= 1'b0;
    end else begin
      s_cpuif_wr_ack  <= wr_stb;
      s_cpuif_rd_ack  <= rd_stb;
      s_cpuif_rd_data <= rd_stb ? rd_val : '0;
      start_pend      <= wr_stb & (s_cpuif_addr == A_CTRL) &
                         s_cpuif_wr_data[0] & s_cpuif_wr_biten[0];
      if (wr_stb && s_cpuif_addr == A_ADDR) addr_q <= addr_new & 32'hFFFF_FFFC;
      if (wr_stb && s_cpuif_addr == A_LEN)  len_q  <= len_new;
      if (state == ST_DONE) count_q <= bytes_q;
      else if (start_go)    count_q <= '0;
      done_q <= (state == ST_DONE) | (done_q & ~w1c[1] & ~start_go);
      ovf_q  <= (beat & ~store)    | (ovf_q & ~w1c[2] & ~start_go);
      berr_q <= ((state == ST_RESP) & m_axil_bvalid & (m_axil_bresp != 2'b00)) |
                (berr_q & ~w1c[3]);
    end
  end

  always_comb begin
    rd_val = '0;
    case (s_cpuif_addr)
      A_CTRL:   rd_val = {30'b0, irq_en_rd, 1'b0};
      A_STATUS: rd_val = {28'b0, berr_q, ovf_q, done_q, state != ST_IDLE};
      A_ADDR:   rd_val = addr_q;
      A_LEN:    rd_val = {16'b0, len_q};
      A_COUNT:  rd_val = {16'b0, count_q};
      default:  rd_val = '0;
    endcase
  end

`ifdef S2M_DMA_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_stb && s_cpuif_addr == A_CTRL && s_cpuif_wr_biten[1])
        irq_en_q <= s_cpuif_wr_data[1];
      irq_q <= irq_en_q & (done_q | berr_q);
    end
  end

  assign irq_en_rd = irq_en_q;
  assign o_irq     = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign o_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_s2m_dma.sv
// Directed bench for s2m_dma: CPU register sequences, byte streams and an AXI-lite
// slave model with programmable ready delays and error responses.
`timescale 1ns/1ps
module tb_s2m_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_is_wr;
  logic [4:0]  cpu_addr;
  logic [31:0] wr_data, wr_biten, rd_data;
  logic        rd_ack, wr_ack;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        irq;

  always #5 clk = ~clk;

  s2m_dma dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_cpuif_req(req), .s_cpuif_req_is_wr(req_is_wr), .s_cpuif_addr(cpu_addr),
    .s_cpuif_wr_data(wr_data), .s_cpuif_wr_biten(wr_biten),
    .s_cpuif_rd_ack(rd_ack), .s_cpuif_rd_data(rd_data), .s_cpuif_wr_ack(wr_ack),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready), .o_irq(irq)
  );

  int n_chk = 0, n_fail = 0;
  int aw_delay = 0, w_delay = 0, err_idx = -1, b_count = 0;
  int split_cnt = 0, post_rst_valids = 0, beats_acc = 0;
  bit mon_rst = 0;
  logic [31:0] aq[$], dq[$];
  logic [3:0]  sq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // AXI-lite write slave; handshakes are judged on the negedge before the active edge.
  initial begin : slave
    logic aw_hs, w_hs, b_hs, aw_got, w_got;
    logic [31:0] cap_a, cap_d;
    logic [3:0]  cap_s;
    int aw_cnt, w_cnt;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      b_hs  = bvalid & bready;
      cap_a = awaddr; cap_d = wdata; cap_s = wstrb;
      if (awvalid && !wvalid) split_cnt++;
      if (mon_rst && (awvalid || wvalid)) post_rst_valids++;
      @(posedge clk); #1;
      if (!rst_n) begin
        aw_got = 0; w_got = 0; bvalid = 1'b0; aw_cnt = 0; w_cnt = 0;
        awready = (aw_delay == 0); wready = (w_delay == 0);
      end else begin
        if (aw_hs) begin
          aq.push_back(cap_a); aw_got = 1; aw_cnt = 0; awready = (aw_delay == 0);
        end else if (awvalid && !awready) begin
          aw_cnt++; if (aw_cnt >= aw_delay) awready = 1'b1;
        end
        if (w_hs) begin
          dq.push_back(cap_d); sq.push_back(cap_s); w_got = 1; w_cnt = 0; wready = (w_delay == 0);
        end else if (wvalid && !wready) begin
          w_cnt++; if (w_cnt >= w_delay) wready = 1'b1;
        end
        if (b_hs) bvalid = 1'b0;
        if (aw_got && w_got && !bvalid) begin
          bvalid = 1'b1;
          bresp  = (b_count == err_idx) ? 2'b10 : 2'b00;
          b_count++;
          aw_got = 0; w_got = 0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic cpu_wr(input logic [4:0] a, input logic [31:0] d);
    req = 1; req_is_wr = 1; cpu_addr = a; wr_data = d; wr_biten = '1;
    tick();
    req = 0; req_is_wr = 0;
  endtask

  task automatic cpu_rd(input logic [4:0] a, output logic [31:0] d);
    req = 1; req_is_wr = 0; cpu_addr = a;
    tick();
    req = 0;
    d = rd_data;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    logic acc;
    acc = 0;
    tdata = d; tlast = last; tvalid = 1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = tready;
      @(posedge clk); #2;
    end
    tvalid = 0; tlast = 0;
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
    else beats_acc++;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    v = 32'h1;
    for (int i = 0; i < 100 && v[0]; i++) cpu_rd(5'h04, v);
    chk(tag, {31'b0, v[0]}, 32'd0);
  endtask

  logic [31:0] v;
  int qb, bb;

  initial begin
    rst_n = 0; req = 0; req_is_wr = 0; cpu_addr = '0; wr_data = '0; wr_biten = '0;
    tdata = '0; tvalid = 0; tlast = 0;
    tick(3);
    chk("rst_tready", {31'b0, tready}, 0);
    chk("rst_valids", {29'b0, awvalid, wvalid, bready}, 0);
    chk("rst_acks", {30'b0, rd_ack, wr_ack}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    rst_n = 1;
    tick(2);
    cpu_rd(5'h04, v); chk("rst_status", v, 0);
    chk("rd_ack_pulse", {31'b0, rd_ack}, 1);

    // 6-byte packet into a 64-byte buffer; ADDR low bits read as zero
    cpu_wr(5'h08, 32'h0000_1003);
    chk("wr_ack_pulse", {31'b0, wr_ack}, 1);
    cpu_rd(5'h08, v); chk("addr_rdz", v, 32'h0000_1000);
    cpu_wr(5'h14, 32'hDEAD_BEEF);
    cpu_rd(5'h14, v); chk("unmapped_rd", v, 0);
    cpu_wr(5'h0C, 32'd64);
    qb = aq.size();
    cpu_wr(5'h00, 32'h1);
    chk("tready_ack_cycle", {31'b0, tready}, 0);
    tick();
    chk("tready_collect", {31'b0, tready}, 1);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    wait_idle("t1_idle");
    chk("t1_nwr", aq.size() - qb, 2);
    chk("t1_addr0", aq[qb], 32'h1000);
    chk("t1_data0", dq[qb], 32'h0403_0201);
    chk("t1_strb0", {28'b0, sq[qb]}, 32'hF);
    chk("t1_addr1", aq[qb+1], 32'h1004);
    chk("t1_data1", dq[qb+1] & 32'hFFFF, 32'h0605);
    chk("t1_strb1", {28'b0, sq[qb+1]}, 32'h3);
    cpu_rd(5'h10, v); chk("t1_count", v, 6);
    cpu_rd(5'h04, v); chk("t1_status", v, 32'h2);

    // LEN=3 with 8 beats: partial word flushed only at tlast
    cpu_wr(5'h04, 32'hE);
    cpu_rd(5'h04, v); chk("w1c_clear", v, 0);
    cpu_wr(5'h08, 32'h2000); cpu_wr(5'h0C, 32'd3);
    qb = aq.size(); bb = beats_acc;
    cpu_wr(5'h00, 32'h1); tick();
    for (int i = 1; i <= 7; i++) send(8'h10 + 8'(i), 1'b0);
    tick(3);
    chk("t2_no_early_wr", aq.size() - qb, 0);
    send(8'h18, 1'b1);
    wait_idle("t2_idle");
    chk("t2_beats", beats_acc - bb, 8);
    chk("t2_nwr", aq.size() - qb, 1);
    chk("t2_addr", aq[qb], 32'h2000);
    chk("t2_data", dq[qb] & 32'h00FF_FFFF, 32'h0013_1211);
    chk("t2_strb", {28'b0, sq[qb]}, 32'h7);
    cpu_rd(5'h10, v); chk("t2_count", v, 3);
    cpu_rd(5'h04, v); chk("t2_status", v, 32'h6);

    // Single-beat packet with slow AWREADY and WREADY
    cpu_wr(5'h04, 32'hE);
    aw_delay = 3; w_delay = 1; awready = 0; wready = 0;
    cpu_wr(5'h08, 32'h3000); cpu_wr(5'h0C, 32'd64);
    qb = aq.size(); split_cnt = 0;
    cpu_wr(5'h00, 32'h1); tick();
    send(8'hAB, 1'b1);
    wait_idle("t3_idle");
    chk("t3_nwr", aq.size() - qb, 1);
    chk("t3_nw", dq.size() - qb, 1);
    chk("t3_addr", aq[qb], 32'h3000);
    chk("t3_data", dq[qb] & 32'hFF, 32'hAB);
    chk("t3_strb", {28'b0, sq[qb]}, 32'h1);
    chk("t3_split", {31'b0, split_cnt > 0}, 1);
    cpu_rd(5'h10, v); chk("t3_count", v, 1);
    aw_delay = 0; w_delay = 0; tick(2); awready = 1; wready = 1;

    // LEN=0: everything discarded, no writes
    cpu_wr(5'h04, 32'hE);
    cpu_wr(5'h08, 32'h3800); cpu_wr(5'h0C, 32'd0);
    qb = aq.size();
    cpu_wr(5'h00, 32'h1); tick();
    send(8'h55, 1'b0); send(8'h66, 1'b1);
    wait_idle("t4_idle");
    chk("t4_nwr", aq.size() - qb, 0);
    cpu_rd(5'h10, v); chk("t4_count", v, 0);
    cpu_rd(5'h04, v); chk("t4_status", v, 32'h6);

    // 4-word packet, SLVERR on the first word
    cpu_wr(5'h04, 32'hE);
    cpu_wr(5'h08, 32'h4000); cpu_wr(5'h0C, 32'd64);
    cpu_wr(5'h00, 32'h2);
    qb = aq.size(); err_idx = b_count;
    cpu_wr(5'h00, 32'h3); tick();
    for (int i = 0; i < 16; i++) send(8'(i), i == 15);
    wait_idle("t5_idle");
    chk("t5_nwr", aq.size() - qb, 4);
    chk("t5_addr3", aq[qb+3], 32'h400C);
    chk("t5_data3", dq[qb+3], 32'h0F0E_0D0C);
    cpu_rd(5'h10, v); chk("t5_count", v, 16);
    cpu_rd(5'h04, v); chk("t5_status", v, 32'hA);
`ifdef S2M_DMA_IRQ_EN
    cpu_rd(5'h00, v); chk("t5_ctrl", v, 32'h2);
    chk("t5_irq_set", {31'b0, irq}, 1);
    cpu_wr(5'h04, 32'h8); tick(2);
    chk("t5_irq_done_held", {31'b0, irq}, 1);
    cpu_wr(5'h04, 32'h2); tick(2);
    chk("t5_irq_clr", {31'b0, irq}, 0);
`else
    cpu_rd(5'h00, v); chk("t5_ctrl", v, 0);
    chk("t5_irq_off", {31'b0, irq}, 0);
    cpu_wr(5'h04, 32'hA); tick(2);
`endif
    cpu_rd(5'h04, v); chk("t5_status_clr", v, 0);

    // start while busy is ignored; reset mid-packet
    cpu_wr(5'h08, 32'h5000); cpu_wr(5'h0C, 32'd64);
    qb = aq.size();
    cpu_wr(5'h00, 32'h1); tick();
    send(8'h21, 1'b0); send(8'h22, 1'b0);
    cpu_wr(5'h00, 32'h1);
    tick();
    cpu_rd(5'h04, v); chk("t6_busy", v, 32'h1);
    send(8'h23, 1'b0); send(8'h24, 1'b0);
    for (int i = 0; i < 50 && aq.size() == qb; i++) tick();
    tick(3);
    chk("t6_nwr", aq.size() - qb, 1);
    chk("t6_addr", aq[qb], 32'h5000);
    chk("t6_data", dq[qb], 32'h2423_2221);
    chk("t6_strb", {28'b0, sq[qb]}, 32'hF);
    send(8'h25, 1'b0);
    rst_n = 0; tick(2); rst_n = 1;
    mon_rst = 1;
    tick();
    chk("t6_tready", {31'b0, tready}, 0);
    cpu_rd(5'h04, v); chk("t6_status", v, 0);
    cpu_rd(5'h08, v); chk("t6_addr_rst", v, 0);
    tick(20);
    chk("t6_no_valids", post_rst_valids, 0);
    chk("t6_no_more_wr", aq.size() - qb, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
